// File: rtl/accel_pkg.sv
// Constants and types shared by the systolic feeder and the PE array it drives.
// Holds the feeder FSM state type and the default array geometry.
package accel_pkg;

  localparam int ACCEL_N          = 4;
  localparam int ACCEL_DATA_WIDTH = 16;
  localparam int ACCEL_KW         = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } feeder_state_e;

  // The last pushed step reaches PE(N-1,N-1) after 2N-2 stages and accumulates one edge later.
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Step handshake bus of the systolic feeder: one column of A and one row of B per transfer.
// The producer side uses the master modport, the feeder uses the slave modport.
interface systolic_feeder_if
  import accel_pkg::*;
#(
  parameter int N          = ACCEL_N,
  parameter int DATA_WIDTH = ACCEL_DATA_WIDTH
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] in_a;
  logic [N*DATA_WIDTH-1:0] in_b;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    output in_ready
  );

endinterface

// File: rtl/skew_delay_line.sv
// Chain of DEPTH registers with synchronous reset to zero, used to skew one array lane.
// DEPTH=0 is a plain wire; the common stage-0 register sits in front of every lane.
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d_in,
  output logic [DATA_WIDTH-1:0] d_out
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign d_out = d_in;
  end else begin : g_chain
    logic [DATA_WIDTH-1:0] stage_q [DEPTH];
    logic [DATA_WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
      stage_d[0] = d_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign d_out = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_feeder.sv
// Feeds the west and north edges of an N x N systolic array with skewed k-steps and
// sequences clear/accumulate/done; FEEDER_PERF_EN adds a bubble counter output.
module systolic_feeder
  import accel_pkg::*;
#(
  parameter int N          = ACCEL_N,
  parameter int DATA_WIDTH = ACCEL_DATA_WIDTH,
  parameter int KW         = ACCEL_KW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  output logic                    busy,
  output logic                    done,
  systolic_feeder_if.slave        step_if,
  output logic [N*DATA_WIDTH-1:0] west_out,
  output logic [N*DATA_WIDTH-1:0] north_out,
  output logic                    acc_en,
  output logic                    array_clr
`ifdef FEEDER_PERF_EN
  ,
  output logic [15:0]             bubble_cnt
`endif
);

  localparam int DCW = (2 * N > 1) ? $clog2(2 * N) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(drain_cycles(N) - 1);

  feeder_state_e           state_q, state_d;
  logic [KW-1:0]           k_len_q, k_len_d;
  logic [KW-1:0]           k_cnt_q, k_cnt_d;
  logic [KW-1:0]           k_cnt_inc;
  logic [DCW-1:0]          drain_cnt_q, drain_cnt_d;
  logic [N*DATA_WIDTH-1:0] stage_a_q, stage_a_d;
  logic [N*DATA_WIDTH-1:0] stage_b_q, stage_b_d;
  logic                    handshake;

  assign handshake = step_if.in_valid && (state_q == ST_FEED);
  assign k_cnt_inc = k_cnt_q + KW'(1);

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    k_cnt_d     = k_cnt_q;
    drain_cnt_d = drain_cnt_q;
    // Non-handshake cycles push zeros so bubbles contribute nothing to the products.
    stage_a_d   = '0;
    stage_b_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_len_d = k_len;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        k_cnt_d     = '0;
        drain_cnt_d = '0;
        state_d     = (k_len_q != '0) ? ST_FEED : ST_DONE;
      end
      ST_FEED: begin
        if (handshake) begin
          stage_a_d = step_if.in_a;
          stage_b_d = step_if.in_b;
          k_cnt_d   = k_cnt_inc;
          if (k_cnt_inc == k_len_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q + DCW'(1);
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_len_q     <= '0;
      k_cnt_q     <= '0;
      drain_cnt_q <= '0;
      stage_a_q   <= '0;
      stage_b_q   <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      k_cnt_q     <= k_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      stage_a_q   <= stage_a_d;
      stage_b_q   <= stage_b_d;
    end
  end

  assign busy             = (state_q != ST_IDLE);
  assign done             = (state_q == ST_DONE);
  assign array_clr        = (state_q == ST_CLEAR);
  assign acc_en           = (state_q == ST_FEED) || (state_q == ST_DRAIN);
  assign step_if.in_ready = (state_q == ST_FEED);

  // Lane i adds i registers behind stage 0, so PE(r,c) sees A[r][k] and B[k][c] together.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_delay_line #(
      .DEPTH      (i),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_west (
      .clk   (clk),
      .rst   (rst),
      .d_in  (stage_a_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .d_out (west_out[i*DATA_WIDTH +: DATA_WIDTH])
    );

    skew_delay_line #(
      .DEPTH      (i),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_north (
      .clk   (clk),
      .rst   (rst),
      .d_in  (stage_b_q[i*DATA_WIDTH +: DATA_WIDTH]),
      .d_out (north_out[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

`ifdef FEEDER_PERF_EN
  logic [15:0] bubble_q, bubble_d;

  always_comb begin
    bubble_d = bubble_q;
    if (state_q == ST_CLEAR) begin
      bubble_d = '0;
    end else if ((state_q == ST_FEED) && !step_if.in_valid && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: random jobs feed a behavioural PE array, results
// and done timing are predicted from A x B and the handshake edges; lanes from the skew rule.
module tb_systolic_feeder;
  import accel_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int KW   = 8;
  localparam int MAXK = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            busy, done, acc_en, array_clr;
  logic [N*DW-1:0] west_out, north_out;
`ifdef FEEDER_PERF_EN
  logic [15:0]     bubble_cnt;
`endif

  systolic_feeder_if #(.N(N), .DATA_WIDTH(DW)) step_if ();

  systolic_feeder #(.N(N), .DATA_WIDTH(DW), .KW(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .done      (done),
    .step_if   (step_if),
    .west_out  (west_out),
    .north_out (north_out),
    .acc_en    (acc_en),
    .array_clr (array_clr)
`ifdef FEEDER_PERF_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; "cycle x" is the interval after edge x.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int                done_cyc;
    logic [N*N*32-1:0] c_exp;
    int                bubbles;
  } job_t;

  job_t            job_q[$];
  job_t            j_mon;
  logic [N*DW-1:0] exp_w [int];
  logic [N*DW-1:0] exp_n [int];
  int              a_mat [N][MAXK];
  int              b_mat [MAXK][N];
  bit              mon_en = 1'b0;

  // Behavioural PE array: A flows east, B flows south, one register per PE.
  logic [31:0]   pe_acc [N][N];
  logic [DW-1:0] pe_a   [N][N];
  logic [DW-1:0] pe_b   [N][N];

  function automatic logic [DW-1:0] a_at(input int r, input int c);
    return (c == 0) ? west_out[r*DW +: DW] : pe_a[r][c-1];
  endfunction

  function automatic logic [DW-1:0] b_at(input int r, input int c);
    return (r == 0) ? north_out[c*DW +: DW] : pe_b[r-1][c];
  endfunction

  always @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (rst || array_clr) begin
          pe_acc[r][c] <= '0;
          pe_a[r][c]   <= '0;
          pe_b[r][c]   <= '0;
        end else begin
          pe_a[r][c] <= a_at(r, c);
          pe_b[r][c] <= b_at(r, c);
          if (acc_en) pe_acc[r][c] <= pe_acc[r][c] + 32'(a_at(r, c)) * 32'(b_at(r, c));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic push_lanes(input int t, input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    logic [N*DW-1:0] tw, tn;
    for (int i = 0; i < N; i++) begin
      tw = exp_w.exists(t + i) ? exp_w[t + i] : '0;
      tn = exp_n.exists(t + i) ? exp_n[t + i] : '0;
      tw[i*DW +: DW] = a[i*DW +: DW];
      tn[i*DW +: DW] = b[i*DW +: DW];
      exp_w[t + i] = tw;
      exp_n[t + i] = tn;
    end
  endtask

  task automatic drop_lanes_from(input int t);
    int keys[$];
    foreach (exp_w[k]) if (k >= t) keys.push_back(k);
    foreach (keys[i]) exp_w.delete(keys[i]);
    keys.delete();
    foreach (exp_n[k]) if (k >= t) keys.push_back(k);
    foreach (keys[i]) exp_n.delete(keys[i]);
  endtask

  // Monitor: lanes every cycle against the skew map; results and timing on each done pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("west_lanes", west_out, exp_w.exists(cyc) ? exp_w[cyc] : '0);
      chk("north_lanes", north_out, exp_n.exists(cyc) ? exp_n[cyc] : '0);
      if (done) begin
        if (job_q.size() == 0) begin
          chk("unexpected_done", done, 1'b0);
        end else begin
          j_mon = job_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(j_mon.done_cyc));
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              chk("pe_result", pe_acc[r][c], j_mon.c_exp[(r*N+c)*32 +: 32]);
`ifdef FEEDER_PERF_EN
          chk("bubble_cnt", bubble_cnt, 64'(j_mon.bubbles));
`endif
        end
      end else if (job_q.size() > 0 && cyc >= job_q[0].done_cyc) begin
        chk("missing_done", done, 1'b1);
        void'(job_q.pop_front());
      end
    end
  end

  // vmode: 0 valid always high, 1 toggling starting low, 2 random.
  task automatic run_job(input int klen, input int vmode, input int abort_after, input bit poke_start);
    int              e, hs, bub, guard;
    int              cacc [N][N];
    logic [N*DW-1:0] va, vb;
    bit              v;
    job_t            j;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) cacc[r][c] = 0;
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(klen);
    e = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    k_len = KW'($urandom);
    chk("clear_pulse", array_clr, 1'b1);
    chk("acc_en_in_clear", acc_en, 1'b0);
    if (klen == 0) begin
      j.done_cyc = e + 1;
      j.c_exp    = '0;
      j.bubbles  = 0;
      job_q.push_back(j);
      @(negedge clk);
      chk("no_ready_k0", step_if.in_ready, 1'b0);
      chk("no_acc_k0", acc_en, 1'b0);
    end else begin
      hs = 0;
      bub = 0;
      guard = 0;
      @(negedge clk);
      while (hs < klen && guard < 1000) begin
        chk("ready_in_feed", step_if.in_ready, 1'b1);
        chk("acc_en_in_feed", acc_en, 1'b1);
        case (vmode)
          0: v = 1'b1;
          1: v = ((cyc - (e + 1)) % 2) == 1;
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        if (v) begin
          for (int i = 0; i < N; i++) begin
            va[i*DW +: DW] = DW'(a_mat[i][hs]);
            vb[i*DW +: DW] = DW'(b_mat[hs][i]);
          end
          push_lanes(cyc + 1, va, vb);
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              cacc[r][c] += a_mat[r][hs] * b_mat[hs][c];
          hs++;
        end else begin
          va = {$urandom, $urandom};
          vb = {$urandom, $urandom};
          bub++;
        end
        step_if.in_valid = v;
        step_if.in_a     = va;
        step_if.in_b     = vb;
        if (v && hs == klen) begin
          j.done_cyc = cyc + 1 + drain_cycles(N);
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              j.c_exp[(r*N+c)*32 +: 32] = 32'(cacc[r][c]);
          j.bubbles = bub;
          job_q.push_back(j);
        end
        @(negedge clk);
        guard++;
        if (abort_after > 0 && hs == abort_after) begin
          step_if.in_valid = 1'b0;
          rst = 1'b1;
          drop_lanes_from(cyc + 1);
          @(negedge clk);
          chk("busy_after_rst", busy, 1'b0);
          chk("acc_en_after_rst", acc_en, 1'b0);
          rst = 1'b0;
          return;
        end
      end
      step_if.in_valid = 1'b0;
      chk("ready_after_last", step_if.in_ready, 1'b0);
      chk("acc_en_in_drain", acc_en, 1'b1);
      if (poke_start) begin
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(7);
        @(negedge clk);
        start = 1'b0;
      end
    end
    guard = 0;
    while (job_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (job_q.size() > 0) begin
      chk("job_timeout", 64'(job_q.size()), 64'd0);
      job_q.delete();
    end
    @(negedge clk);
    chk("idle_after_done", busy, 1'b0);
  endtask

  task automatic fill_random(input int klen);
    for (int k = 0; k < klen; k++)
      for (int i = 0; i < N; i++) begin
        a_mat[i][k] = int'($urandom_range(0, 255));
        b_mat[k][i] = int'($urandom_range(0, 255));
      end
  endtask

  initial begin
    step_if.in_valid = 1'b0;
    step_if.in_a     = '0;
    step_if.in_b     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_acc_en", acc_en, 1'b0);
    chk("rst_array_clr", array_clr, 1'b0);
    chk("rst_in_ready", step_if.in_ready, 1'b0);
    chk("rst_west", west_out, '0);
    chk("rst_north", north_out, '0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Full job: A = identity, B = 1..16 row-major, so results equal B.
    for (int k = 0; k < N; k++)
      for (int i = 0; i < N; i++) begin
        a_mat[i][k] = (i == k) ? 1 : 0;
        b_mat[k][i] = k * N + i + 1;
      end
    run_job(4, 0, 0, 1'b0);
    run_job(4, 1, 0, 1'b0);

    // Single step skew pattern.
    for (int i = 0; i < N; i++) begin
      a_mat[i][0] = i + 1;
      b_mat[0][i] = i + 5;
    end
    run_job(1, 0, 0, 1'b0);

    run_job(0, 0, 0, 1'b0);

    fill_random(4);
    run_job(4, 0, 2, 1'b0);
    run_job(4, 0, 0, 1'b0);

    fill_random(4);
    run_job(4, 0, 0, 1'b1);

    for (int n = 0; n < 6; n++) begin
      int kl;
      kl = int'($urandom_range(1, MAXK));
      fill_random(kl);
      run_job(kl, 2, 0, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Drives the north and west edges of the N x N systolic PE array that computes C = A x B.
- Accepts one k-step per handshake: column k of A and row k of B.
- Skews lane i by i cycles, so PE(r,c) sees A[r][k] and B[k][c] on the same cycle.
- Generates the array-wide accumulate enable and clear, and reports completion to the controller.

Parameters:
- N, 4, array dimension (lanes per edge).
- DATA_WIDTH, 16, lane width; matches the PE data width.
- KW, 8, width of k_len (maximum k_len = 2^KW-1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- k_len  in  KW  inner dimension; sampled with start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse in DONE.
- in_valid  in  1  step data valid.
- in_ready  out  1  high exactly in FEED.
- in_a  in  N*DATA_WIDTH  lane r = A[r][k].
- in_b  in  N*DATA_WIDTH  lane c = B[k][c].
- west_out  out  N*DATA_WIDTH  lane r drives input_west of PE(r,0).
- north_out  out  N*DATA_WIDTH  lane c drives input_north of PE(0,c).
- acc_en  out  1  drives accumulate_enable of all PEs.
- array_clr  out  1  one-cycle clear, ORed into the array reset.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset state: all registers clear. State = IDLE. busy, done, acc_en, array_clr, in_ready = 0. All skew stages = 0, so west_out and north_out read 0.
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- IDLE: on start, latch k_len and go to CLEAR.
- CLEAR: one cycle with array_clr=1. Next state is FEED if k_len != 0, else DONE.
- FEED: in_ready=1, acc_en=1.
  - Each edge with in_valid&in_ready pushes in_a/in_b into skew stage 0 and increments k_cnt.
  - Edges without a handshake push zeros (bubble; the products are 0, so results are unaffected).
  - The handshake that makes k_cnt == k_len moves to DRAIN.
- DRAIN: acc_en=1, zeros are pushed, lasts exactly 2N-1 cycles (drain_cnt), then go to DONE.
  - Rationale: the last step reaches PE(N-1,N-1) after 2N-2 register stages and accumulates on the following edge.
- DONE: done=1 for one cycle, then IDLE.
- acc_en is high exactly in FEED and DRAIN.
- Skew: lane i passes through 1+i registers. A value pushed at edge t is visible on lane i after edge t+i, i.e. for exactly one cycle.
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.
- start while busy: ignored; k_len is not re-sampled.
- Reset mid-job: everything returns to the reset state on the next edge. A partial job is abandoned and not restarted.
- Arithmetic: k_cnt is KW bits and drain_cnt is clog2(2N) bits; neither wraps within a job. Data is passed through unmodified.

Optional Feature:
- Macro: FEEDER_PERF_EN.
- Defined: adds output bubble_cnt [15:0].
  - Cleared in CLEAR.
  - Increments on each FEED cycle without a handshake; saturates at 16'hFFFF.
  - Holds its value after DONE until the next start.
- Undefined: no port, no logic.

Decomposition:
- Shared package accel_pkg:
  - FSM state typedef (IDLE, CLEAR, FEED, DRAIN, DONE).
  - Default DATA_WIDTH and N constants, shared with the PE array.
- One sub-module, skew_delay_line:
  - Parameters DEPTH, DATA_WIDTH.
  - Chain of DEPTH registers with synchronous reset to 0.
  - Instantiated per lane with DEPTH=i.
  - DEPTH=0 degenerates to a wire behind the common stage-0 register.

Test Plan:
- Full job, feeder plus 4x4 PE array: N=4, k_len=4, A=identity, B=1..16 row-major, in_valid held high, start at edge e.
  - CLEAR in cycle e+1, FEED cycles e+2..e+5, DRAIN cycles e+6..e+12, done=1 only in cycle e+13.
  - PE results equal B.
- Skew: k_len=1, in_a={4,3,2,1} (lane0=1), in_b={8,7,6,5} (lane0=5), handshake at edge t.
  - West lane i reads i+1 and north lane i reads i+5 only in the cycle after edge t+i; zero otherwise.
- Bubbles: same job as the full-job test with in_valid toggling every cycle starting low.
  - Identical final results.
  - Lanes are zero in cycles derived from bubbles.
  - done is delayed by exactly the number of bubble cycles.
  - With FEEDER_PERF_EN, bubble_cnt equals the number of FEED cycles without a handshake.
- k_len=0: start leads to array_clr=1 for one cycle, then done=1 in the following cycle. acc_en and in_ready never assert.
- Reset mid-FEED: assert rst after 2 handshakes.
  - Next cycle: busy=0, all lanes 0, acc_en=0.
  - A subsequent k_len=4 job produces correct results.
- start pulsed during DRAIN with k_len=7: ignored; done timing and results unchanged.
